// File: rtl/bus_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bus_arb_pkg
// Brief    : Shared FSM state types, ID width helper and AXI encodings for the
//            N-master AXI arbiter.
// Revision : 1.0
// ============================================================================
package bus_arb_pkg;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ADDR = 2'd1,
        R_DATA = 2'd2
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_ADDR = 2'd1,
        W_DATA = 2'd2,
        W_RESP = 2'd3
    } wr_state_t;

    localparam logic [1:0] c_INCR = 2'b01;
    localparam logic [1:0] c_OKAY = 2'b00;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin pick: first requester at or after ptr.
// Revision : 1.0
// ============================================================================
module rr_arbiter
    import bus_arb_pkg::*;
#(
    parameter  int NUM_MASTERS = 4,
    localparam int ID_WIDTH    = id_width(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [ID_WIDTH-1:0]    ptr,
    output logic [ID_WIDTH-1:0]    grant_id,
    output logic                   grant_valid
);

    logic [ID_WIDTH-1:0] w_idx;

    // Scan from farthest to nearest so the closest requester to ptr wins last.
    always_comb begin
        grant_id    = '0;
        grant_valid = 1'b0;
        w_idx       = '0;
        for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
            w_idx = ID_WIDTH'((int'(ptr) + k) % NUM_MASTERS);
            if (req[w_idx]) begin
                grant_id    = w_idx;
                grant_valid = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/axi_n_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : axi_n_master_arbiter
// Brief    : Round-robin N-master AXI arbiter, independent read/write paths,
//            grant held per burst. Option BUS_ARB_WLAST_GEN_EN derives s_WLAST
//            from the latched AWLEN instead of the master's WLAST.
// Revision : 1.0
// ============================================================================
module axi_n_master_arbiter
    import bus_arb_pkg::*;
#(
    parameter  int NUM_MASTERS         = 4,
    parameter  int ADDR_WIDTH          = 32,
    parameter  int READ_CHANNEL_WIDTH  = 32,
    parameter  int READ_BURST_LEN      = 8,
    parameter  int WRITE_CHANNEL_WIDTH = 32,
    parameter  int WRITE_BURST_LEN     = 8,
    localparam int ID_WIDTH            = id_width(NUM_MASTERS)
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic [NUM_MASTERS-1:0]                     m_ARVALID,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]          m_ARADDR,
    input  logic [NUM_MASTERS*READ_BURST_LEN-1:0]      m_ARLEN,
    input  logic [NUM_MASTERS*3-1:0]                   m_ARSIZE,
    input  logic [NUM_MASTERS*2-1:0]                   m_ARBURST,
    output logic [NUM_MASTERS-1:0]                     m_ARREADY,
    output logic [NUM_MASTERS-1:0]                     m_RVALID,
    output logic [NUM_MASTERS*READ_CHANNEL_WIDTH-1:0]  m_RDATA,
    output logic [NUM_MASTERS-1:0]                     m_RLAST,
    output logic [NUM_MASTERS*2-1:0]                   m_RRESP,
    input  logic [NUM_MASTERS-1:0]                     m_RREADY,
    input  logic [NUM_MASTERS-1:0]                     m_AWVALID,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]          m_AWADDR,
    input  logic [NUM_MASTERS*WRITE_BURST_LEN-1:0]     m_AWLEN,
    input  logic [NUM_MASTERS*3-1:0]                   m_AWSIZE,
    input  logic [NUM_MASTERS*2-1:0]                   m_AWBURST,
    output logic [NUM_MASTERS-1:0]                     m_AWREADY,
    input  logic [NUM_MASTERS-1:0]                     m_WVALID,
    input  logic [NUM_MASTERS*WRITE_CHANNEL_WIDTH-1:0] m_WDATA,
    input  logic [NUM_MASTERS-1:0]                     m_WLAST,
    output logic [NUM_MASTERS-1:0]                     m_WREADY,
    output logic [NUM_MASTERS-1:0]                     m_BVALID,
    output logic [NUM_MASTERS*2-1:0]                   m_BRESP,
    input  logic [NUM_MASTERS-1:0]                     m_BREADY,
    output logic                                       s_ARVALID,
    output logic [ADDR_WIDTH-1:0]                      s_ARADDR,
    output logic [READ_BURST_LEN-1:0]                  s_ARLEN,
    output logic [2:0]                                 s_ARSIZE,
    output logic [1:0]                                 s_ARBURST,
    input  logic                                       s_ARREADY,
    input  logic                                       s_RVALID,
    input  logic [READ_CHANNEL_WIDTH-1:0]              s_RDATA,
    input  logic                                       s_RLAST,
    input  logic [1:0]                                 s_RRESP,
    output logic                                       s_RREADY,
    output logic                                       s_AWVALID,
    output logic [ADDR_WIDTH-1:0]                      s_AWADDR,
    output logic [WRITE_BURST_LEN-1:0]                 s_AWLEN,
    output logic [2:0]                                 s_AWSIZE,
    output logic [1:0]                                 s_AWBURST,
    input  logic                                       s_AWREADY,
    output logic                                       s_WVALID,
    output logic [WRITE_CHANNEL_WIDTH-1:0]             s_WDATA,
    output logic                                       s_WLAST,
    input  logic                                       s_WREADY,
    input  logic                                       s_BVALID,
    input  logic [1:0]                                 s_BRESP,
    output logic                                       s_BREADY,
    output logic                                       rd_busy,
    output logic                                       wr_busy,
    output logic [ID_WIDTH-1:0]                        rd_grant_id,
    output logic [ID_WIDTH-1:0]                        wr_grant_id
);

    rd_state_t                  r_rd_state;
    wr_state_t                  r_wr_state;
    logic [ID_WIDTH-1:0]        r_rd_grant, r_rd_ptr, r_wr_grant, r_wr_ptr;
    logic                       r_rd_busy, r_wr_busy;
    logic [WRITE_BURST_LEN:0]   r_wr_beats;

    logic [ID_WIDTH-1:0]        w_rd_pick, w_wr_pick;
    logic                       w_rd_pick_valid, w_wr_pick_valid;
    logic                       w_ar_phase, w_r_phase, w_aw_phase, w_w_phase, w_b_phase;
    logic                       w_wlast;

    function automatic logic [ID_WIDTH-1:0] next_id(input logic [ID_WIDTH-1:0] id);
        return (int'(id) == NUM_MASTERS - 1) ? '0 : id + 1'b1;
    endfunction

    rr_arbiter #(.NUM_MASTERS(NUM_MASTERS)) u_rd_arb (
        .req         (m_ARVALID),
        .ptr         (r_rd_ptr),
        .grant_id    (w_rd_pick),
        .grant_valid (w_rd_pick_valid)
    );

    rr_arbiter #(.NUM_MASTERS(NUM_MASTERS)) u_wr_arb (
        .req         (m_AWVALID),
        .ptr         (r_wr_ptr),
        .grant_id    (w_wr_pick),
        .grant_valid (w_wr_pick_valid)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_state <= R_IDLE;
            r_rd_grant <= '0;
            r_rd_ptr   <= '0;
            r_rd_busy  <= 1'b0;
        end else begin
            case (r_rd_state)
                R_IDLE: if (w_rd_pick_valid) begin
                    r_rd_grant <= w_rd_pick;
                    r_rd_busy  <= 1'b1;
                    r_rd_state <= R_ADDR;
                end
                R_ADDR: if (s_ARVALID && s_ARREADY) r_rd_state <= R_DATA;
                R_DATA: if (s_RVALID && s_RREADY && s_RLAST) begin
                    r_rd_ptr   <= next_id(r_rd_grant);
                    r_rd_busy  <= 1'b0;
                    r_rd_state <= R_IDLE;
                end
                default: r_rd_state <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_state <= W_IDLE;
            r_wr_grant <= '0;
            r_wr_ptr   <= '0;
            r_wr_busy  <= 1'b0;
            r_wr_beats <= '0;
        end else begin
            case (r_wr_state)
                W_IDLE: if (w_wr_pick_valid) begin
                    r_wr_grant <= w_wr_pick;
                    r_wr_busy  <= 1'b1;
                    r_wr_state <= W_ADDR;
                end
                W_ADDR: if (s_AWVALID && s_AWREADY) begin
                    r_wr_beats <= {1'b0, s_AWLEN};
                    r_wr_state <= W_DATA;
                end
                W_DATA: if (s_WVALID && s_WREADY) begin
                    // Saturate so an over-long master burst cannot wrap the count.
                    if (r_wr_beats != '0) r_wr_beats <= r_wr_beats - 1'b1;
                    if (w_wlast) r_wr_state <= W_RESP;
                end
                W_RESP: if (s_BVALID && s_BREADY) begin
                    r_wr_ptr   <= next_id(r_wr_grant);
                    r_wr_busy  <= 1'b0;
                    r_wr_state <= W_IDLE;
                end
                default: r_wr_state <= W_IDLE;
            endcase
        end
    end

    assign rd_busy     = r_rd_busy;
    assign wr_busy     = r_wr_busy;
    assign rd_grant_id = r_rd_grant;
    assign wr_grant_id = r_wr_grant;

    assign w_ar_phase = (r_rd_state == R_ADDR);
    assign w_r_phase  = (r_rd_state == R_DATA);
    assign w_aw_phase = (r_wr_state == W_ADDR);
    assign w_w_phase  = (r_wr_state == W_DATA);
    assign w_b_phase  = (r_wr_state == W_RESP);

`ifdef BUS_ARB_WLAST_GEN_EN
    assign w_wlast = (r_wr_beats == '0);
`else
    assign w_wlast = m_WLAST[r_wr_grant];
`endif

    assign s_ARVALID = w_ar_phase & m_ARVALID[r_rd_grant];
    assign s_ARADDR  = w_ar_phase ? m_ARADDR[int'(r_rd_grant)*ADDR_WIDTH +: ADDR_WIDTH] : '0;
    assign s_ARLEN   = w_ar_phase ? m_ARLEN[int'(r_rd_grant)*READ_BURST_LEN +: READ_BURST_LEN] : '0;
    assign s_ARSIZE  = w_ar_phase ? m_ARSIZE[int'(r_rd_grant)*3 +: 3] : '0;
    assign s_ARBURST = w_ar_phase ? m_ARBURST[int'(r_rd_grant)*2 +: 2] : '0;
    assign s_RREADY  = w_r_phase & m_RREADY[r_rd_grant];

    assign s_AWVALID = w_aw_phase & m_AWVALID[r_wr_grant];
    assign s_AWADDR  = w_aw_phase ? m_AWADDR[int'(r_wr_grant)*ADDR_WIDTH +: ADDR_WIDTH] : '0;
    assign s_AWLEN   = w_aw_phase ? m_AWLEN[int'(r_wr_grant)*WRITE_BURST_LEN +: WRITE_BURST_LEN] : '0;
    assign s_AWSIZE  = w_aw_phase ? m_AWSIZE[int'(r_wr_grant)*3 +: 3] : '0;
    assign s_AWBURST = w_aw_phase ? m_AWBURST[int'(r_wr_grant)*2 +: 2] : '0;
    assign s_WVALID  = w_w_phase & m_WVALID[r_wr_grant];
    assign s_WDATA   = w_w_phase ? m_WDATA[int'(r_wr_grant)*WRITE_CHANNEL_WIDTH +: WRITE_CHANNEL_WIDTH] : '0;
    assign s_WLAST   = w_w_phase & w_wlast;
    assign s_BREADY  = w_b_phase & m_BREADY[r_wr_grant];

    // Only the grantee of the active phase sees slave responses; others read 0.
    for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_master
        logic w_sel_ar, w_sel_r, w_sel_aw, w_sel_w, w_sel_b;

        assign w_sel_ar = w_ar_phase && (r_rd_grant == ID_WIDTH'(gi));
        assign w_sel_r  = w_r_phase  && (r_rd_grant == ID_WIDTH'(gi));
        assign w_sel_aw = w_aw_phase && (r_wr_grant == ID_WIDTH'(gi));
        assign w_sel_w  = w_w_phase  && (r_wr_grant == ID_WIDTH'(gi));
        assign w_sel_b  = w_b_phase  && (r_wr_grant == ID_WIDTH'(gi));

        assign m_ARREADY[gi] = w_sel_ar & s_ARREADY;
        assign m_RVALID[gi]  = w_sel_r & s_RVALID;
        assign m_RDATA[gi*READ_CHANNEL_WIDTH +: READ_CHANNEL_WIDTH] = w_sel_r ? s_RDATA : '0;
        assign m_RLAST[gi]   = w_sel_r & s_RLAST;
        assign m_RRESP[gi*2 +: 2] = w_sel_r ? s_RRESP : c_OKAY;
        assign m_AWREADY[gi] = w_sel_aw & s_AWREADY;
        assign m_WREADY[gi]  = w_sel_w & s_WREADY;
        assign m_BVALID[gi]  = w_sel_b & s_BVALID;
        assign m_BRESP[gi*2 +: 2] = w_sel_b ? s_BRESP : c_OKAY;
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_n_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_n_master_arbiter
// Brief    : Directed self-checking bench for axi_n_master_arbiter; the bench
//            acts as both masters and slave. Honours BUS_ARB_WLAST_GEN_EN.
// Revision : 1.0
// ============================================================================
module tb_axi_n_master_arbiter;
    import bus_arb_pkg::*;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LW = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    m_ARVALID, m_ARREADY, m_RVALID, m_RLAST, m_RREADY;
    logic [N*AW-1:0] m_ARADDR, m_AWADDR;
    logic [N*LW-1:0] m_ARLEN, m_AWLEN;
    logic [N*3-1:0]  m_ARSIZE, m_AWSIZE;
    logic [N*2-1:0]  m_ARBURST, m_AWBURST, m_RRESP, m_BRESP;
    logic [N*DW-1:0] m_RDATA, m_WDATA;
    logic [N-1:0]    m_AWVALID, m_AWREADY, m_WVALID, m_WLAST, m_WREADY, m_BVALID, m_BREADY;
    logic            s_ARVALID, s_ARREADY, s_RVALID, s_RLAST, s_RREADY;
    logic [AW-1:0]   s_ARADDR, s_AWADDR;
    logic [LW-1:0]   s_ARLEN, s_AWLEN;
    logic [2:0]      s_ARSIZE, s_AWSIZE;
    logic [1:0]      s_ARBURST, s_AWBURST, s_RRESP, s_BRESP;
    logic [DW-1:0]   s_RDATA, s_WDATA;
    logic            s_AWVALID, s_AWREADY, s_WVALID, s_WLAST, s_WREADY, s_BVALID, s_BREADY;
    logic            rd_busy, wr_busy;
    logic [1:0]      rd_grant_id, wr_grant_id;

    int n_cmp = 0;
    int n_bad = 0;

    axi_n_master_arbiter #(
        .NUM_MASTERS(N), .ADDR_WIDTH(AW), .READ_CHANNEL_WIDTH(DW), .READ_BURST_LEN(LW),
        .WRITE_CHANNEL_WIDTH(DW), .WRITE_BURST_LEN(LW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .m_ARVALID(m_ARVALID), .m_ARADDR(m_ARADDR), .m_ARLEN(m_ARLEN), .m_ARSIZE(m_ARSIZE),
        .m_ARBURST(m_ARBURST), .m_ARREADY(m_ARREADY), .m_RVALID(m_RVALID), .m_RDATA(m_RDATA),
        .m_RLAST(m_RLAST), .m_RRESP(m_RRESP), .m_RREADY(m_RREADY),
        .m_AWVALID(m_AWVALID), .m_AWADDR(m_AWADDR), .m_AWLEN(m_AWLEN), .m_AWSIZE(m_AWSIZE),
        .m_AWBURST(m_AWBURST), .m_AWREADY(m_AWREADY), .m_WVALID(m_WVALID), .m_WDATA(m_WDATA),
        .m_WLAST(m_WLAST), .m_WREADY(m_WREADY), .m_BVALID(m_BVALID), .m_BRESP(m_BRESP),
        .m_BREADY(m_BREADY),
        .s_ARVALID(s_ARVALID), .s_ARADDR(s_ARADDR), .s_ARLEN(s_ARLEN), .s_ARSIZE(s_ARSIZE),
        .s_ARBURST(s_ARBURST), .s_ARREADY(s_ARREADY), .s_RVALID(s_RVALID), .s_RDATA(s_RDATA),
        .s_RLAST(s_RLAST), .s_RRESP(s_RRESP), .s_RREADY(s_RREADY),
        .s_AWVALID(s_AWVALID), .s_AWADDR(s_AWADDR), .s_AWLEN(s_AWLEN), .s_AWSIZE(s_AWSIZE),
        .s_AWBURST(s_AWBURST), .s_AWREADY(s_AWREADY), .s_WVALID(s_WVALID), .s_WDATA(s_WDATA),
        .s_WLAST(s_WLAST), .s_WREADY(s_WREADY), .s_BVALID(s_BVALID), .s_BRESP(s_BRESP),
        .s_BREADY(s_BREADY),
        .rd_busy(rd_busy), .wr_busy(wr_busy), .rd_grant_id(rd_grant_id), .wr_grant_id(wr_grant_id)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rdat(input int m, input int b);
        return 32'hA000_0000 | 32'(m << 8) | 32'(b);
    endfunction

    function automatic logic [31:0] wdat(input int m, input int b);
        return 32'hB000_0000 | 32'(m << 16) | 32'(b);
    endfunction

    task automatic set_ar(input int m, input logic [31:0] addr, input logic [7:0] len);
        m_ARADDR[m*AW +: AW] = addr;
        m_ARLEN[m*LW +: LW]  = len;
        m_ARSIZE[m*3 +: 3]   = 3'd2;
        m_ARBURST[m*2 +: 2]  = c_INCR;
        m_ARVALID[m]         = 1'b1;
    endtask

    task automatic set_aw(input int m, input logic [31:0] addr, input logic [7:0] len);
        m_AWADDR[m*AW +: AW] = addr;
        m_AWLEN[m*LW +: LW]  = len;
        m_AWSIZE[m*3 +: 3]   = 3'd2;
        m_AWBURST[m*2 +: 2]  = c_INCR;
        m_AWVALID[m]         = 1'b1;
    endtask

    // Entered one cycle before the expected grant edge, with the request set.
    task automatic do_read(input int m, input int len, input int nbeats, input logic [31:0] addr);
        #1;
        chk("rd_idle_arvalid", s_ARVALID, 0);
        step();
        chk("rd_grant_id", rd_grant_id, m);
        chk("rd_busy", rd_busy, 1);
        chk("s_arvalid", s_ARVALID, 1);
        chk("s_araddr", s_ARADDR, addr);
        chk("s_arlen", s_ARLEN, len);
        chk("s_arburst", s_ARBURST, c_INCR);
        s_ARREADY = 1'b1;
        #1;
        chk("m_arready", m_ARREADY, 128'(1) << m);
        step();
        m_ARVALID[m] = 1'b0;
        s_ARREADY    = 1'b0;
        for (int b = 0; b < nbeats; b++) begin
            s_RVALID = 1'b1;
            s_RDATA  = rdat(m, b);
            s_RLAST  = (b == len);
            #1;
            chk("m_rvalid", m_RVALID, 128'(1) << m);
            chk("m_rdata", m_RDATA, 128'(rdat(m, b)) << (32 * m));
            chk("m_rlast", m_RLAST, (b == len) ? (128'(1) << m) : 128'(0));
            chk("s_rready", s_RREADY, 1);
            step();
        end
        if (nbeats == len + 1) begin
            s_RVALID = 1'b0;
            s_RLAST  = 1'b0;
        end
    endtask

    task automatic do_write(input int m, input int len, input int nbeats, input logic [31:0] addr);
        logic exp_last;
        #1;
        chk("wr_idle_awvalid", s_AWVALID, 0);
        step();
        chk("wr_grant_id", wr_grant_id, m);
        chk("wr_busy", wr_busy, 1);
        chk("s_awvalid", s_AWVALID, 1);
        chk("s_awaddr", s_AWADDR, addr);
        chk("s_awlen", s_AWLEN, len);
        s_AWREADY = 1'b1;
        #1;
        chk("m_awready", m_AWREADY, 128'(1) << m);
        step();
        m_AWVALID[m] = 1'b0;
        s_AWREADY    = 1'b0;
        s_WREADY     = 1'b1;
        for (int b = 0; b < nbeats; b++) begin
            m_WVALID[m]          = 1'b1;
            m_WDATA[m*DW +: DW]  = wdat(m, b);
            m_WLAST[m]           = (b == nbeats - 1);
`ifdef BUS_ARB_WLAST_GEN_EN
            exp_last = (b == len);
`else
            exp_last = (b == nbeats - 1);
`endif
            #1;
            chk("s_wlast", s_WLAST, exp_last);
            if (b < 4 || b >= nbeats - 2) begin
                chk("s_wvalid", s_WVALID, 1);
                chk("s_wdata", s_WDATA, wdat(m, b));
                chk("m_wready", m_WREADY, 128'(1) << m);
            end
            step();
        end
        m_WLAST[m] = 1'b0;
        s_BVALID   = 1'b1;
        s_BRESP    = 2'b10;
        #1;
        chk("wresp_no_wvalid", s_WVALID, 0);
        chk("wresp_no_wready", m_WREADY, 0);
        chk("m_bvalid", m_BVALID, 128'(1) << m);
        chk("m_bresp", m_BRESP, 128'(2) << (2 * m));
        chk("s_bready", s_BREADY, 1);
        step();
        m_WVALID[m] = 1'b0;
        s_BVALID    = 1'b0;
        s_BRESP     = 2'b00;
        s_WREADY    = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        m_ARVALID = '0; m_ARADDR = '0; m_ARLEN = '0; m_ARSIZE = '0; m_ARBURST = '0;
        m_AWVALID = '0; m_AWADDR = '0; m_AWLEN = '0; m_AWSIZE = '0; m_AWBURST = '0;
        m_WVALID = '0; m_WDATA = '0; m_WLAST = '0;
        m_RREADY = '1; m_BREADY = '1;
        s_ARREADY = 0; s_RVALID = 0; s_RDATA = '0; s_RLAST = 0; s_RRESP = '0;
        s_AWREADY = 0; s_WREADY = 0; s_BVALID = 0; s_BRESP = '0;

        step();
        step();
        chk("rst_rd_busy", rd_busy, 0);
        chk("rst_wr_busy", wr_busy, 0);
        chk("rst_rd_grant", rd_grant_id, 0);
        chk("rst_wr_grant", wr_grant_id, 0);
        chk("rst_s_arvalid", s_ARVALID, 0);
        chk("rst_s_awvalid", s_AWVALID, 0);
        rst_n = 1'b1;
        step();

        // Lone master 2 read, pointer at 0.
        set_ar(2, 32'h100, 8'd3);
        do_read(2, 3, 4, 32'h100);

        // rd_ptr now 3: masters 0 and 3 -> 3 first, then wrap to 0.
        set_ar(0, 32'h200, 8'd1);
        set_ar(3, 32'h300, 8'd1);
        do_read(3, 1, 2, 32'h300);
        do_read(0, 1, 2, 32'h200);

        // Write from 2 moves wr_ptr to 3, then wrap-around ordering.
        set_aw(2, 32'h400, 8'd3);
        do_write(2, 3, 4, 32'h400);
        set_aw(0, 32'h500, 8'd1);
        set_aw(3, 32'h600, 8'd1);
        do_write(3, 1, 2, 32'h600);
        do_write(0, 1, 2, 32'h500);

`ifdef BUS_ARB_WLAST_GEN_EN
        set_aw(1, 32'h700, 8'd255);
        do_write(1, 255, 256, 32'h700);
`else
        set_aw(1, 32'h700, 8'd7);
        do_write(1, 7, 4, 32'h700);
`endif

        // Concurrent read (master 0) and write (master 1).
        set_ar(0, 32'h3000, 8'd7);
        set_aw(1, 32'h5000, 8'd7);
        fork
            do_read(0, 7, 8, 32'h3000);
            do_write(1, 7, 8, 32'h5000);
        join

        // Reset after 2 of 8 beats from master 1.
        set_ar(1, 32'h6000, 8'd7);
        do_read(1, 7, 2, 32'h6000);
        rst_n = 1'b0;
        step();
        chk("mid_rst_m_rvalid", m_RVALID, 0);
        chk("mid_rst_m_rdata", m_RDATA, 0);
        chk("mid_rst_s_rready", s_RREADY, 0);
        chk("mid_rst_rd_busy", rd_busy, 0);
        chk("mid_rst_rd_grant", rd_grant_id, 0);
        rst_n    = 1'b1;
        s_RVALID = 1'b0;
        set_ar(0, 32'h7000, 8'd3);
        do_read(0, 3, 4, 32'h7000);

        // Contention from reset: 0, 1, 3 with one bubble between bursts.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        set_ar(0, 32'h1000, 8'd1);
        set_ar(1, 32'h2000, 8'd1);
        set_ar(3, 32'h4000, 8'd1);
        do_read(0, 1, 2, 32'h1000);
        do_read(1, 1, 2, 32'h2000);
        do_read(3, 1, 2, 32'h4000);
        #1;
        chk("end_rd_busy", rd_busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
